// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction formats, field positions and encode helpers.
// Optional IMM_RANGE_CHECK_EN adds imm_in_range() for I8 immediate fit checking.
package isa_pkg;

    typedef enum logic [4:0] {
        OP_MV    = 5'b00000,
        OP_ADD   = 5'b00001,
        OP_SUB   = 5'b00010,
        OP_CMP   = 5'b00011,
        OP_LD    = 5'b00100,
        OP_ST    = 5'b00101,
        OP_JR    = 5'b01000,
        OP_JZR   = 5'b01001,
        OP_JNR   = 5'b01010,
        OP_CALLR = 5'b01100,
        OP_MVI   = 5'b10000,
        OP_ADDI  = 5'b10001,
        OP_SUBI  = 5'b10010,
        OP_CMPI  = 5'b10011,
        OP_MVHI  = 5'b10110,
        OP_J     = 5'b11000,
        OP_JZ    = 5'b11001,
        OP_JN    = 5'b11010,
        OP_CALL  = 5'b11100
    } opcode_e;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I8,
        FMT_I11
    } format_e;

    localparam int OPC_LSB   = 0;
    localparam int OPC_W     = 5;
    localparam int RX_LSB    = 5;
    localparam int RY_LSB    = 8;
    localparam int IMM8_LSB  = 8;
    localparam int IMM11_LSB = 5;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST,
            OP_JR, OP_JZR, OP_JNR, OP_CALLR,
            OP_MVI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MVHI,
            OP_J, OP_JZ, OP_JN, OP_CALL: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic format_e op_format(input logic [4:0] op);
        if (!op[4])
            return FMT_R;
        else if (!op[3])
            return FMT_I8;
        else
            return FMT_I11;
    endfunction

    function automatic logic [15:0] encode_instr(input logic [4:0]  op,
                                                 input logic [2:0]  rx,
                                                 input logic [2:0]  ry,
                                                 input logic [10:0] imm);
        logic [15:0] w;
        w = '0;
        w[OPC_LSB +: OPC_W] = op;
        case (op_format(op))
            FMT_R: begin
                w[RX_LSB +: 3] = rx;
                w[RY_LSB +: 3] = ry;
            end
            FMT_I8: begin
                w[RX_LSB +: 3]   = rx;
                w[IMM8_LSB +: 8] = imm[7:0];
            end
            default: w[IMM11_LSB +: 11] = imm;
        endcase
        return w;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // mvhi loads an unsigned high byte; other I8 ops take a signed 8-bit value.
    function automatic logic imm_in_range(input logic [4:0] op, input logic [10:0] imm);
        if (op_format(op) != FMT_I8)
            return 1'b1;
        if (op == OP_MVHI)
            return (imm[10:8] == 3'b000);
        return (imm[10:7] == 4'b0000) || (imm[10:7] == 4'b1111);
    endfunction
`endif

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded instruction words; DEPTH must be a power of two.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_writer.sv
// Packs decoded instruction fields into 16-bit words and streams them into memory.
// Optional IMM_RANGE_CHECK_EN drops out-of-range I8 immediates and adds err_range.
module instr_encoder_writer
    import isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_rx,
    input  logic [2:0]        in_ry,
    input  logic [10:0]       in_imm,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wrdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_written,
    output logic              err_illegal,
    output logic              addr_wrap
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic              err_range
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e           state;
    logic             accept;
    logic             op_legal;
    logic             beat_ok;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      enc_word;

    assign op_legal = is_legal_op(in_opcode);
`ifdef IMM_RANGE_CHECK_EN
    logic imm_ok;
    assign imm_ok  = imm_in_range(in_opcode, in_imm);
    assign beat_ok = op_legal && imm_ok;
`else
    assign beat_ok = op_legal;
`endif

    // in_ready only looks at registered state so it never follows mem_ready.
    assign in_ready = (state == ST_LOAD) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && beat_ok && !fifo_full;
    assign mem_wr   = !fifo_empty;
    assign pop      = mem_wr && mem_ready;
    assign enc_word = encode_instr(in_opcode, in_rx, in_ry, in_imm);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (enc_word),
        .pop       (pop),
        .pop_data  (mem_wrdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            mem_addr      <= '0;
            words_written <= '0;
            err_illegal   <= 1'b0;
            addr_wrap     <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
            err_range     <= 1'b0;
`endif
        end else begin
            if (pop) begin
                mem_addr      <= mem_addr + ADDR_W'(2);
                words_written <= words_written + 16'd1;
                if (mem_addr == LAST_ADDR)
                    addr_wrap <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_LOAD;
                        mem_addr      <= base_addr & ~ADDR_W'(1);
                        words_written <= '0;
                        err_illegal   <= 1'b0;
                        addr_wrap     <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
                        err_range     <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (accept && !op_legal)
                        err_illegal <= 1'b1;
`ifdef IMM_RANGE_CHECK_EN
                    if (accept && op_legal && !imm_ok)
                        err_range <= 1'b1;
`endif
                    if (accept && in_last)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty)
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Directed self-checking bench for instr_encoder_writer; honours IMM_RANGE_CHECK_EN.
module tb_instr_encoder_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  in_opcode;
    logic [2:0]  in_rx;
    logic [2:0]  in_ry;
    logic [10:0] in_imm;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wrdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic [15:0] words_written;
    logic        err_illegal;
    logic        addr_wrap;
`ifdef IMM_RANGE_CHECK_EN
    logic        err_range;
`endif

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;
    int mark;
    int done_mark;
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    always #5 clk = ~clk;

    instr_encoder_writer #(
        .FIFO_DEPTH (4),
        .ADDR_W     (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last       (in_last),
        .in_opcode     (in_opcode),
        .in_rx         (in_rx),
        .in_ry         (in_ry),
        .in_imm        (in_imm),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wrdata    (mem_wrdata),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .err_illegal   (err_illegal),
        .addr_wrap     (addr_wrap)
`ifdef IMM_RANGE_CHECK_EN
        ,
        .err_range     (err_range)
`endif
    );

    // Inputs change just after the rising edge, so the falling edge sees what the next edge will.
    always @(negedge clk) begin
        if (reset && mem_wr && mem_ready) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wrdata);
        end
        if (done)
            done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] wr_addr_at(input int idx);
        return (idx < wr_addr_q.size()) ? wr_addr_q[idx] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] wr_data_at(input int idx);
        return (idx < wr_data_q.size()) ? wr_data_q[idx] : 16'hxxxx;
    endfunction

    task automatic start_session(input logic [15:0] base);
        mark      = wr_addr_q.size();
        done_mark = done_cnt;
        base_addr = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic apply_stimulus(input string tag, input logic [4:0] op, input logic [2:0] rx,
                                  input logic [2:0] ry, input logic [10:0] imm, input logic last);
        int n = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_rx     = rx;
        in_ry     = ry;
        in_imm    = imm;
        in_last   = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_output({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check_output({tag, "_idle"}, {31'b0, busy}, 32'd0);
        check_output({tag, "_done"}, done_cnt - done_mark, 32'd1);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [15:0] addr, input logic [15:0] data);
        check_output({tag, "_addr"}, {16'b0, wr_addr_at(mark + idx)}, {16'b0, addr});
        check_output({tag, "_data"}, {16'b0, wr_data_at(mark + idx)}, {16'b0, data});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_rx = '0; in_ry = '0; in_imm = '0; mem_ready = 1'b0;
        tick(); tick();
        check_output("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_done", {31'b0, done}, 32'd0);
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check_output("rst_addr", {16'b0, mem_addr}, 32'd0);
        check_output("rst_words", {16'b0, words_written}, 32'd0);
        check_output("rst_err", {30'b0, err_illegal, addr_wrap}, 32'd0);
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();

        $display("[TB] single add");
        start_session(16'h0100);
        check_output("t1_busy", {31'b0, busy}, 32'd1);
        apply_stimulus("t1_b0", 5'b00001, 3'd1, 3'd2, 11'h000, 1'b1);
        check_output("t1_lat_wr", {31'b0, mem_wr}, 32'd1);
        check_output("t1_lat_data", {16'b0, mem_wrdata}, 32'h0221);
        wait_idle("t1");
        check_output("t1_count", wr_addr_q.size() - mark, 32'd1);
        check_write("t1_w0", 0, 16'h0100, 16'h0221);
        check_output("t1_words", {16'b0, words_written}, 32'd1);

        $display("[TB] mvi then j, odd base");
        start_session(16'h0201);
        apply_stimulus("t2_b0", 5'b10000, 3'd3, 3'd0, 11'h07F, 1'b0);
        apply_stimulus("t2_b1", 5'b11000, 3'd0, 3'd0, 11'h123, 1'b1);
        wait_idle("t2");
        check_output("t2_count", wr_addr_q.size() - mark, 32'd2);
        check_write("t2_w0", 0, 16'h0200, 16'h7F70);
        check_write("t2_w1", 1, 16'h0202, 16'h2478);
        check_output("t2_words", {16'b0, words_written}, 32'd2);

        $display("[TB] illegal opcode with last");
        start_session(16'h0300);
        apply_stimulus("t3_b0", 5'b00111, 3'd1, 3'd1, 11'h000, 1'b1);
        wait_idle("t3");
        check_output("t3_count", wr_addr_q.size() - mark, 32'd0);
        check_output("t3_err_illegal", {31'b0, err_illegal}, 32'd1);
        check_output("t3_words", {16'b0, words_written}, 32'd0);

        $display("[TB] back-pressure with full FIFO");
        mem_ready = 1'b0;
        start_session(16'h0400);
        check_output("t4_err_cleared", {31'b0, err_illegal}, 32'd0);
        apply_stimulus("t4_b0", 5'b00000, 3'd1, 3'd0, 11'h000, 1'b0);
        apply_stimulus("t4_b1", 5'b00010, 3'd2, 3'd3, 11'h000, 1'b0);
        apply_stimulus("t4_b2", 5'b00011, 3'd7, 3'd7, 11'h000, 1'b0);
        apply_stimulus("t4_b3", 5'b01000, 3'd5, 3'd0, 11'h000, 1'b0);
        check_output("t4_full_ready", {31'b0, in_ready}, 32'd0);
        start = 1'b1; base_addr = 16'h0900;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_opcode = 5'b11100; in_imm = 11'h7FF; in_last = 1'b1;
        tick(); tick();
        check_output("t4_still_blocked", {31'b0, in_ready}, 32'd0);
        check_output("t4_no_writes", wr_addr_q.size() - mark, 32'd0);
        check_output("t4_head_addr", {16'b0, mem_addr}, 32'h0400);
        check_output("t4_head_wr", {31'b0, mem_wr}, 32'd1);
        mem_ready = 1'b1;
        apply_stimulus("t4_b4", 5'b11100, 3'd0, 3'd0, 11'h7FF, 1'b1);
        wait_idle("t4");
        check_output("t4_count", wr_addr_q.size() - mark, 32'd5);
        check_write("t4_w0", 0, 16'h0400, 16'h0020);
        check_write("t4_w1", 1, 16'h0402, 16'h0342);
        check_write("t4_w2", 2, 16'h0404, 16'h07E3);
        check_write("t4_w3", 3, 16'h0406, 16'h00A8);
        check_write("t4_w4", 4, 16'h0408, 16'hFFFC);
        check_output("t4_words", {16'b0, words_written}, 32'd5);

        $display("[TB] address wrap");
        start_session(16'hFFFE);
        check_output("t5_wrap_clear", {31'b0, addr_wrap}, 32'd0);
        apply_stimulus("t5_b0", 5'b00001, 3'd1, 3'd2, 11'h000, 1'b0);
        apply_stimulus("t5_b1", 5'b00000, 3'd1, 3'd0, 11'h000, 1'b1);
        wait_idle("t5");
        check_write("t5_w0", 0, 16'hFFFE, 16'h0221);
        check_write("t5_w1", 1, 16'h0000, 16'h0020);
        check_output("t5_wrap", {31'b0, addr_wrap}, 32'd1);

        $display("[TB] addi imm 0x180");
        start_session(16'h0600);
        apply_stimulus("t6_b0", 5'b10001, 3'd1, 3'd0, 11'h180, 1'b1);
        wait_idle("t6");
`ifdef IMM_RANGE_CHECK_EN
        check_output("t6_count", wr_addr_q.size() - mark, 32'd0);
        check_output("t6_err_range", {31'b0, err_range}, 32'd1);
        check_output("t6_err_illegal", {31'b0, err_illegal}, 32'd0);
`else
        check_output("t6_count", wr_addr_q.size() - mark, 32'd1);
        check_write("t6_w0", 0, 16'h0600, 16'h8031);
`endif

        $display("[TB] reset mid-session");
        mem_ready = 1'b0;
        start_session(16'h0500);
        apply_stimulus("t7_b0", 5'b00001, 3'd1, 3'd2, 11'h000, 1'b0);
        apply_stimulus("t7_b1", 5'b00010, 3'd2, 3'd3, 11'h000, 1'b0);
        apply_stimulus("t7_b2", 5'b00011, 3'd3, 3'd4, 11'h000, 1'b0);
        check_output("t7_pre_wr", {31'b0, mem_wr}, 32'd1);
        reset = 1'b0;
        #1;
        check_output("t7_rst_wr", {31'b0, mem_wr}, 32'd0);
        check_output("t7_rst_busy", {31'b0, busy}, 32'd0);
        mem_ready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick(); tick(); tick(); tick();
        check_output("t7_no_writes", wr_addr_q.size() - mark, 32'd0);
        check_output("t7_post_wr", {31'b0, mem_wr}, 32'd0);
        check_output("t7_post_busy", {31'b0, busy}, 32'd0);
        check_output("t7_post_words", {16'b0, words_written}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
